// File: rtl/song_clk_gen.sv
// ---------------------------------------------------------------------------
// song_clk_gen
//   Clock/tempo generator for the song player. It derives a free-running
//   tone reference clock and a note-step clock from the board clock. The
//   note-step clock has play/pause/stop control and a selectable tempo. It
//   also provides a one-cycle beat pulse and a beat index.
//
// Build option:
//   SONG_CLK_GEN_FAST_SIM_EN - when defined, TONE_DIV is forced to 2 and
//   BEAT_HALF is forced to 8 so that simulations stay short. Tempo scaling
//   still applies, giving half-periods of 4, 8 or 16 cycles.
//
// Ports:
//   i_clk_50MHz  system clock
//   i_rst        asynchronous reset, active-high
//   i_start      one-cycle pulse: play or resume
//   i_pause      one-cycle pulse: toggle between pause and play
//   i_stop       one-cycle pulse: stop and rewind
//   i_tempo      00/11 nominal, 01 double speed, 10 half speed
//   o_clk_5MHz   tone reference clock, 50% duty
//   o_clk_4Hz    note-step clock, 50% duty while running
//   o_beat_tick  one-cycle pulse on each o_clk_4Hz rising transition
//   o_beat_cnt   number of o_clk_4Hz rises since the last stop (wraps)
//   o_running    high in the RUN state
//   o_paused     high in the PAUSE state
//
// States:
//   state  | meaning
//   IDLE   | stopped and rewound; note clock held low
//   RUN    | beat counter advancing; note clock toggling
//   PAUSE  | beat counter, note clock level and beat index frozen
// ---------------------------------------------------------------------------
module song_clk_gen #(
  parameter int TONE_DIV  = 10,
  parameter int BEAT_HALF = 6250000,
  parameter int CNT_W     = 25
) (
  input  logic       i_clk_50MHz,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_pause,
  input  logic       i_stop,
  input  logic [1:0] i_tempo,
  output logic       o_clk_5MHz,
  output logic       o_clk_4Hz,
  output logic       o_beat_tick,
  output logic [7:0] o_beat_cnt,
  output logic       o_running,
  output logic       o_paused
);

`ifdef SONG_CLK_GEN_FAST_SIM_EN
  localparam int TONE_DIV_E  = 2;
  localparam int BEAT_HALF_E = 8;
`else
  localparam int TONE_DIV_E  = TONE_DIV;
  localparam int BEAT_HALF_E = BEAT_HALF;
`endif

  localparam int TONE_W = (TONE_DIV_E > 2) ? $clog2(TONE_DIV_E / 2) : 1;
  localparam logic [TONE_W-1:0] TONE_TC = TONE_W'(TONE_DIV_E / 2 - 1);

  localparam logic [CNT_W-1:0] HALF_NOM_M1  = CNT_W'(BEAT_HALF_E - 1);
  localparam logic [CNT_W-1:0] HALF_FAST_M1 = CNT_W'(BEAT_HALF_E / 2 - 1);
  localparam logic [CNT_W-1:0] HALF_SLOW_M1 = CNT_W'(2 * BEAT_HALF_E - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

  logic [TONE_W-1:0] r_tone_cnt;
  logic              r_clk_5mhz;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;

  logic [CNT_W-1:0]  r_beat_cnt;
  logic [CNT_W-1:0]  w_half_m1;
  logic              w_beat_tc;
  logic              r_clk_4hz;
  logic              r_beat_tick;
  logic [7:0]        r_beat_idx;
  logic [1:0]        r_tempo_q;

  // Tone path: free-running, unaffected by the player controls.
  always_ff @(posedge i_clk_50MHz or posedge i_rst) begin
    if (i_rst) begin
      r_tone_cnt <= '0;
      r_clk_5mhz <= 1'b0;
    end else if (r_tone_cnt == TONE_TC) begin
      r_tone_cnt <= '0;
      r_clk_5mhz <= ~r_clk_5mhz;
    end else begin
      r_tone_cnt <= r_tone_cnt + TONE_W'(1);
    end
  end

  // Control priority is stop > start > pause. In RUN a start wins over a
  // simultaneous pause and does nothing, so the player keeps running.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!i_stop && i_start) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (i_stop)                   w_state_nxt = ST_IDLE;
        else if (!i_start && i_pause) w_state_nxt = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (i_stop)                  w_state_nxt = ST_IDLE;
        else if (i_start || i_pause) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk_50MHz or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_half_m1 = HALF_NOM_M1;
    case (r_tempo_q)
      2'b01:   w_half_m1 = HALF_FAST_M1;
      2'b10:   w_half_m1 = HALF_SLOW_M1;
      default: w_half_m1 = HALF_NOM_M1;
    endcase
  end

  assign w_beat_tc = (r_beat_cnt == w_half_m1);

  // Beat path. A stop clears everything, even on a terminal count, so no
  // beat pulse is issued in that cycle. The tempo is only resampled when the
  // half-period restarts (or while idle), so a tempo change never cuts a
  // half-period short.
  always_ff @(posedge i_clk_50MHz or posedge i_rst) begin
    if (i_rst) begin
      r_beat_cnt  <= '0;
      r_clk_4hz   <= 1'b0;
      r_beat_tick <= 1'b0;
      r_beat_idx  <= 8'd0;
      r_tempo_q   <= 2'b00;
    end else begin
      r_beat_tick <= 1'b0;
      if (i_stop || (r_state == ST_IDLE)) begin
        r_beat_cnt <= '0;
        r_clk_4hz  <= 1'b0;
        r_beat_idx <= 8'd0;
      end else if (r_state == ST_RUN) begin
        if (w_beat_tc) begin
          r_beat_cnt <= '0;
          r_clk_4hz  <= ~r_clk_4hz;
          if (!r_clk_4hz) begin
            r_beat_tick <= 1'b1;
            r_beat_idx  <= r_beat_idx + 8'd1;
          end
        end else begin
          r_beat_cnt <= r_beat_cnt + CNT_W'(1);
        end
      end

      if ((r_state == ST_IDLE) || ((r_state == ST_RUN) && !i_stop && w_beat_tc))
        r_tempo_q <= i_tempo;
    end
  end

  assign o_clk_5MHz  = r_clk_5mhz;
  assign o_clk_4Hz   = r_clk_4hz;
  assign o_beat_tick = r_beat_tick;
  assign o_beat_cnt  = r_beat_idx;
  assign o_running   = (r_state == ST_RUN);
  assign o_paused    = (r_state == ST_PAUSE);

endmodule

// File: tb/tb_song_clk_gen.sv
// ---------------------------------------------------------------------------
// tb_song_clk_gen
//   Directed bench for song_clk_gen with TONE_DIV=10, BEAT_HALF=50, CNT_W=8.
//   Cycle numbers in the comments count rising edges after the edge that
//   sampled start (or after reset release for the tone checks).
// ---------------------------------------------------------------------------
module tb_song_clk_gen;

  logic       clk;
  logic       rst;
  logic       start;
  logic       pause;
  logic       stop;
  logic [1:0] tempo;
  logic       clk5;
  logic       clk4;
  logic       beat_tick;
  logic [7:0] beat_cnt;
  logic       running;
  logic       paused;

  int total = 0;
  int bad   = 0;

  int tog_e[$];
  int n_ticks;
  int tick_mis;
  int cnt_first;

  song_clk_gen #(
    .TONE_DIV (10),
    .BEAT_HALF(50),
    .CNT_W    (8)
  ) dut (
    .i_clk_50MHz(clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_pause    (pause),
    .i_stop     (stop),
    .i_tempo    (tempo),
    .o_clk_5MHz (clk5),
    .o_clk_4Hz  (clk4),
    .o_beat_tick(beat_tick),
    .o_beat_cnt (beat_cnt),
    .o_running  (running),
    .o_paused   (paused)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_pause();
    pause = 1'b1; tick(); pause = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  // Runs n cycles, noting on which cycle clk_4Hz changes level, how many
  // beat pulses appear and whether each pulse lines up with a rising edge.
  task automatic record(input int n);
    logic prev;
    prev = clk4;
    tog_e.delete();
    n_ticks   = 0;
    tick_mis  = 0;
    cnt_first = 0;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (clk4 !== prev) tog_e.push_back(i);
      if (beat_tick !== (clk4 & ~prev)) tick_mis++;
      if (beat_tick === 1'b1) begin
        n_ticks++;
        if (n_ticks == 1) cnt_first = int'(beat_cnt);
      end
      prev = clk4;
    end
  endtask

  initial begin
    int errs;
    int first5;

    rst = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0; tempo = 2'b00;
    #1 rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;

    // Reset state
    chk("rst_clk5", clk5, 1'b0);
    chk("rst_clk4", clk4, 1'b0);
    chk("rst_tick", beat_tick, 1'b0);
    chk("rst_cnt", beat_cnt, 8'd0);
    chk("rst_running", running, 1'b0);
    chk("rst_paused", paused, 1'b0);

    // Reset release, no start: tone clock period 10, first rise at 5,
    // note path quiet for 1000 cycles.
    rst = 1'b0;
    errs = 0;
    first5 = 0;
    for (int n = 1; n <= 1000; n++) begin
      tick();
      if (clk5 !== 1'(((n / 5) % 2))) errs++;
      if (first5 == 0 && clk5 === 1'b1) first5 = n;
      if (clk4 !== 1'b0 || beat_cnt !== 8'd0 || running !== 1'b0 || paused !== 1'b0) errs++;
    end
    chk("tone_first_rise", first5, 5);
    chk("idle_quiet_errs", errs, 0);

    // Pause in IDLE is ignored
    pulse_pause();
    chk("idle_pause_ign_paused", paused, 1'b0);
    chk("idle_pause_ign_running", running, 1'b0);

    // Nominal tempo run for 1000 cycles
    pulse_start();
    chk("start_running", running, 1'b1);
    chk("start_paused", paused, 1'b0);
    record(1000);
    chk("nom_toggles", tog_e.size(), 20);
    chk("nom_first_rise", tog_e[0], 50);
    chk("nom_first_fall", tog_e[1], 100);
    chk("nom_second_rise", tog_e[2], 150);
    chk("nom_ticks", n_ticks, 10);
    chk("nom_cnt_first", cnt_first, 1);
    chk("nom_tick_align", tick_mis, 0);
    chk("nom_cnt_1000", beat_cnt, 8'd10);
    pulse_stop();
    chk("stop_running", running, 1'b0);
    chk("stop_clk4", clk4, 1'b0);
    chk("stop_cnt", beat_cnt, 8'd0);

    // Pause after 20 RUN cycles, resume 30 cycles later; rise at 80
    pulse_start();
    ticks(19);
    pulse_pause();
    chk("pause_paused", paused, 1'b1);
    chk("pause_running", running, 1'b0);
    ticks(29);
    chk("pause_hold_paused", paused, 1'b1);
    chk("pause_hold_clk4", clk4, 1'b0);
    chk("pause_hold_cnt", beat_cnt, 8'd0);
    pulse_pause();
    chk("resume_running", running, 1'b1);
    chk("resume_paused", paused, 1'b0);
    ticks(29);
    chk("resume_c79_clk4", clk4, 1'b0);
    tick();
    chk("resume_c80_clk4", clk4, 1'b1);
    chk("resume_c80_tick", beat_tick, 1'b1);
    chk("resume_c80_cnt", beat_cnt, 8'd1);
    pulse_stop();

    // Tempo 00 -> 01 at cycle 20: toggles at 50, 75, 100, ... (rel. to 20)
    pulse_start();
    ticks(20);
    tempo = 2'b01;
    record(180);
    chk("tempo_toggles", tog_e.size(), 7);
    chk("tempo_t0", tog_e[0], 30);
    chk("tempo_t1", tog_e[1], 55);
    chk("tempo_t3", tog_e[3], 105);
    chk("tempo_tick_align", tick_mis, 0);
    pulse_stop();

    // Half speed: first rise at 100
    tempo = 2'b10;
    pulse_start();
    record(250);
    chk("slow_toggles", tog_e.size(), 2);
    chk("slow_first_rise", tog_e[0], 100);
    chk("slow_fall", tog_e[1], 200);
    pulse_stop();

    // Tempo 11 behaves as nominal
    tempo = 2'b11;
    pulse_start();
    record(60);
    chk("t11_toggles", tog_e.size(), 1);
    chk("t11_first_rise", tog_e[0], 50);
    pulse_stop();
    tempo = 2'b00;

    // Stop and start together on the terminal-count cycle of RUN
    pulse_start();
    ticks(49);
    chk("ss_pre_clk4", clk4, 1'b0);
    stop = 1'b1; start = 1'b1;
    tick();
    stop = 1'b0; start = 1'b0;
    chk("ss_running", running, 1'b0);
    chk("ss_clk4", clk4, 1'b0);
    chk("ss_tick", beat_tick, 1'b0);
    chk("ss_cnt", beat_cnt, 8'd0);
    tick();
    chk("ss_next_running", running, 1'b0);
    chk("ss_next_tick", beat_tick, 1'b0);

    // Stop from PAUSE rewinds; a fresh start rises after 50 again
    pulse_start();
    ticks(10);
    pulse_pause();
    pulse_stop();
    chk("pstop_paused", paused, 1'b0);
    chk("pstop_running", running, 1'b0);
    pulse_start();
    record(50);
    chk("pstop_rewind_toggles", tog_e.size(), 1);
    chk("pstop_rewind_rise", tog_e[0], 50);
    pulse_stop();

    // Reset mid-RUN with clk_4Hz high
    pulse_start();
    ticks(60);
    chk("mid_clk4", clk4, 1'b1);
    chk("mid_cnt", beat_cnt, 8'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_clk5", clk5, 1'b0);
    chk("arst_clk4", clk4, 1'b0);
    chk("arst_cnt", beat_cnt, 8'd0);
    chk("arst_running", running, 1'b0);
    chk("arst_tick", beat_tick, 1'b0);
    chk("arst_paused", paused, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    ticks(4);
    chk("arst_tone_c4", clk5, 1'b0);
    tick();
    chk("arst_tone_c5", clk5, 1'b1);
    ticks(100);
    chk("arst_idle_running", running, 1'b0);
    chk("arst_idle_clk4", clk4, 1'b0);
    pulse_start();
    chk("arst_restart_running", running, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/song_clk_gen.md
Name: song_clk_gen

Overview:
- Clock/tempo generator that sits directly upstream of the song player blocks.
- Derives the tone reference clock (clk_5MHz) and the note-step clock (clk_4Hz) from the 50 MHz board clock. Both are registered square-wave outputs.
- Adds play/pause/stop control and selectable tempo, so the song can be started, frozen and restarted.
- Also produces a one-cycle beat pulse and a beat index for display/debug.

Parameters:
- TONE_DIV, 10, system cycles per clk_5MHz period; must be even and ≥2.
- BEAT_HALF, 6250000, system cycles per clk_4Hz half-period at nominal tempo; must be even and ≥4.
- CNT_W, 25, width of the beat counter; must hold 2*BEAT_HALF-1.

Ports:
- clk_50MHz  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  one-cycle pulse: play or resume.
- pause  in  1  one-cycle pulse: toggle between pause and play.
- stop  in  1  one-cycle pulse: stop and rewind.
- tempo  in  2  00 nominal; 01 double speed (half-period BEAT_HALF/2); 10 half speed (2*BEAT_HALF); 11 nominal.
- clk_5MHz  out  1  tone reference clock, 50% duty.
- clk_4Hz  out  1  note-step clock, 50% duty while running.
- beat_tick  out  1  one-cycle pulse on each clk_4Hz rising transition.
- beat_cnt  out  8  count of clk_4Hz rising edges since stop; wraps 255→0.
- running  out  1  high in RUN state.
- paused  out  1  high in PAUSE state.

Behaviour:
- Reset (async, rst=1):
  - All outputs 0.
  - FSM in IDLE; all counters 0.
  - tempo_q latched to 00.
- Tone path:
  - Free-runs in every FSM state, independent of start/pause/stop.
  - Counter runs 0..TONE_DIV/2-1; clk_5MHz toggles on the terminal count and the counter clears.
  - First rising edge occurs TONE_DIV/2 cycles after rst deasserts.
- FSM states: IDLE, RUN, PAUSE. All inputs are synchronous to clk_50MHz.
- Input priority in one cycle: stop > start > pause.
- IDLE:
  - start → RUN; pause ignored.
  - clk_4Hz held 0; beat counter and beat_cnt held 0.
- RUN:
  - stop → IDLE.
  - pause → PAUSE.
  - start is a no-op.
- PAUSE:
  - stop → IDLE.
  - start or pause → RUN.
  - Beat counter, clk_4Hz level and beat_cnt are frozen.
- Entry to IDLE from any state clears the beat counter, clk_4Hz and beat_cnt on the cycle after stop is sampled.
- Beat path (RUN only):
  - Beat counter increments each cycle.
  - When it equals half-1, it clears and clk_4Hz toggles. half is selected by tempo_q.
- Tempo changes:
  - tempo is sampled into tempo_q only when the beat counter clears, or in IDLE.
  - A mid-half-period tempo change takes effect at the next toggle, so there are no runt pulses.
- Beat outputs on a 0→1 toggle:
  - beat_tick=1 for the same cycle clk_4Hz becomes 1 (both registered together).
  - beat_cnt increments in that same cycle.
- Latency:
  - First clk_4Hz rise occurs after exactly half RUN cycles.
  - Resume from PAUSE continues the remaining count; the total high/low time excludes paused cycles.
- Simultaneous stop with a terminal count: stop wins; no beat_tick is issued.
- Reset mid-operation is immediate (async). The tone clock restarts from 0.

Optional Feature:
- Macro: SONG_CLK_GEN_FAST_SIM_EN.
- Defined: BEAT_HALF is overridden to 8 and TONE_DIV to 2. This gives short-run simulation; tempo scaling still applies (4/8/16).
- Undefined: the parameter values are used unchanged.

Test Plan:
- Bench uses TONE_DIV=10, BEAT_HALF=50, CNT_W=8 unless stated.
- Reset release, no start → clk_5MHz period 10 cycles, first rise at cycle 5; clk_4Hz, beat_cnt, running all 0 for 1000 cycles.
- start pulse at cycle 0, tempo=00 → running=1 at cycle 1; clk_4Hz rises after 50 RUN cycles with beat_tick=1 for 1 cycle and beat_cnt=1; period 100 cycles; beat_cnt=10 after 1000 RUN cycles.
- RUN 20 cycles, pause for 30 cycles, then pause again → paused=1 during the gap; clk_4Hz rise occurs 80 cycles after start; beat_cnt unchanged while paused.
- tempo changed 00→01 mid half-period → the current half-period completes at 50; subsequent half-periods are 25; no pulse shorter than 25 cycles.
- stop and start asserted in the same cycle during RUN → IDLE next cycle; clk_4Hz=0, beat_cnt=0, running=0; no beat_tick.
- rst asserted mid-RUN with clk_4Hz=1 → all outputs 0 immediately; after release the FSM is in IDLE until start.
